// File: rtl/uart_rom_loader_if.sv
// ROM write port driven by uart_rom_loader: one-cycle strobe with address and data.
interface uart_rom_loader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic              rom_wr_en;
    logic [ADDR_W-1:0] rom_wr_addr;
    logic [DATA_W-1:0] rom_wr_data;

    modport master (output rom_wr_en, rom_wr_addr, rom_wr_data);
    modport slave  (input  rom_wr_en, rom_wr_addr, rom_wr_data);
endinterface

// File: rtl/uart_rom_loader.sv
// UART 8N1 program loader: streams big-endian 16-bit words into the instruction ROM and
// holds the CPU in reset until the load completes. Optional trailer: LOADER_CHECKSUM_EN.
module uart_rom_loader #(
    parameter int INSTR_WIDTH        = 16,
    parameter int ROM_REGISTER_COUNT = 2**10,
    parameter int CLKS_PER_BIT       = 434,
    parameter int TIMEOUT_CLKS       = 2**22
) (
    input  logic                                 CLK_50,
    input  logic                                 resetN,
    input  logic                                 uart_rx,
    uart_rom_loader_if.master                    rom,
    output logic                                 cpu_hold,
    output logic                                 loading,
    output logic                                 done,
    output logic                                 error,
    output logic [$clog2(ROM_REGISTER_COUNT):0]  words_loaded
);
    localparam int AW  = $clog2(ROM_REGISTER_COUNT);
    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int TOW = $clog2(TIMEOUT_CLKS + 1);

    // ---------------- UART receiver ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t     rx_state, rx_next;
    logic          rx_meta, rx_sync;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_byte;
    logic          half_tick, bit_tick;
    logic          byte_valid, frame_err;

    assign half_tick = (rx_cnt == CW'(CLKS_PER_BIT / 2 - 1));
    assign bit_tick  = (rx_cnt == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        rx_next    = rx_state;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (rx_state)
            RX_IDLE:  if (!rx_sync) rx_next = RX_START;
            RX_START: if (half_tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_tick && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP: begin
                if (bit_tick) begin
                    rx_next    = RX_IDLE;
                    byte_valid = rx_sync;
                    frame_err  = !rx_sync;
                end
            end
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_byte  <= '0;
        end else begin
            rx_meta  <= uart_rx;
            rx_sync  <= rx_meta;
            rx_state <= rx_next;
            // Counter restarts at the start-bit midpoint and at every data/stop sample
            if (rx_state == RX_IDLE || (rx_state == RX_START && half_tick) || bit_tick)
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + 1'b1;
            if (rx_state == RX_START)
                rx_bit <= '0;
            if (rx_state == RX_DATA && bit_tick) begin
                rx_byte <= {rx_sync, rx_byte[7:1]};
                rx_bit  <= rx_bit + 1'b1;
            end
        end
    end

    // ---------------- Loader FSM ----------------
    typedef enum logic [3:0] {
        S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CSUM_HI, S_CSUM_LO,
`endif
        S_DONE, S_ERROR
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_AFTER_DATA = S_CSUM_HI;
    logic [15:0] csum;
    logic [7:0]  csum_hi;
`else
    localparam state_t S_AFTER_DATA = S_DONE;
`endif

    state_t         state, state_n;
    logic [7:0]     len_hi, hi_byte;
    logic [15:0]    len, len_n;
    logic [TOW-1:0] to_cnt;
    logic           timeout, last_word;

    assign len_n     = {len_hi, rx_byte};
    assign timeout   = loading && !byte_valid && (to_cnt == TOW'(TIMEOUT_CLKS - 1));
    assign last_word = (32'(words_loaded) == 32'(len));

    always_comb begin
        state_n = state;
        case (state)
            S_LEN_HI:  if (byte_valid) state_n = S_LEN_LO;
            S_LEN_LO: begin
                if (byte_valid) begin
                    if (int'(len_n) > ROM_REGISTER_COUNT) state_n = S_ERROR;
                    else if (len_n == '0)                state_n = S_AFTER_DATA;
                    else                                 state_n = S_DATA_HI;
                end
            end
            S_DATA_HI: if (byte_valid) state_n = S_DATA_LO;
            S_DATA_LO: if (byte_valid) state_n = S_WRITE;
            S_WRITE:   state_n = last_word ? S_AFTER_DATA : S_DATA_HI;
`ifdef LOADER_CHECKSUM_EN
            S_CSUM_HI: if (byte_valid) state_n = S_CSUM_LO;
            S_CSUM_LO: if (byte_valid) state_n = ({csum_hi, rx_byte} == csum) ? S_DONE : S_ERROR;
`endif
            S_DONE:    if (byte_valid) state_n = S_LEN_LO;
            S_ERROR:   state_n = S_ERROR;
            default:   state_n = S_ERROR;
        endcase
        if (frame_err || timeout)
            state_n = S_ERROR;
    end

    always_comb begin
        loading  = !(state == S_LEN_HI || state == S_DONE || state == S_ERROR);
        done     = (state == S_DONE);
        cpu_hold = (state != S_DONE);
        error    = (state == S_ERROR);
    end

    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN) begin
            state           <= S_LEN_HI;
            len_hi          <= '0;
            len             <= '0;
            hi_byte         <= '0;
            to_cnt          <= '0;
            words_loaded    <= '0;
            rom.rom_wr_en   <= 1'b0;
            rom.rom_wr_addr <= '0;
            rom.rom_wr_data <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum            <= '0;
            csum_hi         <= '0;
`endif
        end else begin
            state         <= state_n;
            rom.rom_wr_en <= 1'b0;
            if (byte_valid || !loading)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;
            if (byte_valid) begin
                case (state)
                    // A byte in S_DONE starts a fresh load; ROM contents are kept
                    S_LEN_HI, S_DONE: begin
                        len_hi       <= rx_byte;
                        words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum         <= '0;
`endif
                    end
                    S_LEN_LO:  len     <= len_n;
                    S_DATA_HI: hi_byte <= rx_byte;
                    S_DATA_LO: begin
                        rom.rom_wr_en   <= 1'b1;
                        rom.rom_wr_addr <= words_loaded[AW-1:0];
                        rom.rom_wr_data <= INSTR_WIDTH'({hi_byte, rx_byte});
                        words_loaded    <= words_loaded + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        csum            <= csum + {hi_byte, rx_byte};
`endif
                    end
`ifdef LOADER_CHECKSUM_EN
                    S_CSUM_HI: csum_hi <= rx_byte;
`endif
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rom_loader.sv
// Scoreboard bench for uart_rom_loader: expected ROM writes are queued as words are sent.
module tb_uart_rom_loader;
    localparam int CPB = 8;
    localparam int ROM = 16;
    localparam int TO  = 1000;
    localparam int AW  = 4;

    logic        clk = 1'b0;
    logic        resetN = 1'b1;
    logic        uart_rx = 1'b1;
    logic        cpu_hold, loading, done, error;
    logic [AW:0] words_loaded;

    int          checks = 0;
    int          failures = 0;
    int          wr_count = 0;
    logic [19:0] sb[$];
    logic [19:0] sb_exp;

    uart_rom_loader_if #(.ADDR_W(AW), .DATA_W(16)) rom_if();

    uart_rom_loader #(
        .INSTR_WIDTH(16), .ROM_REGISTER_COUNT(ROM), .CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)
    ) dut (
        .CLK_50(clk), .resetN(resetN), .uart_rx(uart_rx), .rom(rom_if),
        .cpu_hold(cpu_hold), .loading(loading), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rom_if.rom_wr_en === 1'b1) begin
            wr_count++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL rom_write unexpected: got addr=%0d data=%h, required no write",
                         rom_if.rom_wr_addr, rom_if.rom_wr_data);
            end else begin
                sb_exp = sb.pop_front();
                if ({rom_if.rom_wr_addr, rom_if.rom_wr_data} !== sb_exp) begin
                    failures++;
                    $display("FAIL rom_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             rom_if.rom_wr_addr, rom_if.rom_wr_data, sb_exp[19:16], sb_exp[15:0]);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic send_word(input logic [3:0] addr, input logic [15:0] w);
        sb.push_back({addr, w});
        send_byte(w[15:8], 1'b1);
        send_byte(w[7:0], 1'b1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetN = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        repeat (2) @(negedge clk);
        sb.delete();
    endtask

    task automatic test_reset();
        #1 resetN = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cpu_hold, loading, done, error, rom_if.rom_wr_en, words_loaded} !== 10'h200) begin
            failures++;
            $display("FAIL reset_outputs: got %b, required %b",
                     {cpu_hold, loading, done, error, rom_if.rom_wr_en, words_loaded}, 10'h200);
        end
        checks++;
        if ({rom_if.rom_wr_addr, rom_if.rom_wr_data} !== 20'h0) begin
            failures++;
            $display("FAIL reset_rom_port: got %h, required 00000",
                     {rom_if.rom_wr_addr, rom_if.rom_wr_data});
        end
        resetN = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_load();
        int c0 = wr_count;
        send_byte(8'h00, 1'b1);
        checks++;
        if ({loading, cpu_hold, done} !== 3'b110) begin
            failures++;
            $display("FAIL basic_loading_flags: got %b, required 110", {loading, cpu_hold, done});
        end
        send_byte(8'h02, 1'b1);
        send_word(4'd0, 16'h1234);
        send_word(4'd1, 16'hABCD);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'hBE, 1'b1);
        send_byte(8'h01, 1'b1);
`endif
        wait_done();
        checks++;
        if ({done, cpu_hold, loading, error, words_loaded} !== {4'b1000, 5'd2}) begin
            failures++;
            $display("FAIL basic_done: got %b, required %b",
                     {done, cpu_hold, loading, error, words_loaded}, {4'b1000, 5'd2});
        end
        checks++;
        if (wr_count - c0 != 2 || sb.size() != 0) begin
            failures++;
            $display("FAIL basic_write_count: got %0d writes (%0d pending), required 2 (0 pending)",
                     wr_count - c0, sb.size());
        end
    endtask

    task automatic test_reload();
        send_byte(8'h00, 1'b1);
        checks++;
        if ({cpu_hold, done, loading, words_loaded} !== {3'b101, 5'd0}) begin
            failures++;
            $display("FAIL reload_restart: got %b, required %b",
                     {cpu_hold, done, loading, words_loaded}, {3'b101, 5'd0});
        end
        send_byte(8'h01, 1'b1);
        send_word(4'd0, 16'hFFFF);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'hFF, 1'b1);
        send_byte(8'hFF, 1'b1);
`endif
        wait_done();
        checks++;
        if ({done, cpu_hold, error, words_loaded} !== {3'b100, 5'd1} || sb.size() != 0) begin
            failures++;
            $display("FAIL reload_done: got %b pending=%0d, required %b pending=0",
                     {done, cpu_hold, error, words_loaded}, sb.size(), {3'b100, 5'd1});
        end
        // Abort between the bytes of a word
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h55, 1'b1);
        resetN = 1'b0;
        @(negedge clk);
        checks++;
        if ({cpu_hold, loading, done, error, rom_if.rom_wr_en, words_loaded} !== 10'h200) begin
            failures++;
            $display("FAIL midload_reset: got %b, required %b",
                     {cpu_hold, loading, done, error, rom_if.rom_wr_en, words_loaded}, 10'h200);
        end
        resetN = 1'b1;
        repeat (2) @(negedge clk);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_word(4'd0, 16'h1234);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
`endif
        wait_done();
        checks++;
        if ({done, words_loaded} !== {1'b1, 5'd1} || sb.size() != 0) begin
            failures++;
            $display("FAIL overwrite_after_reset: got %b pending=%0d, required %b pending=0",
                     {done, words_loaded}, sb.size(), {1'b1, 5'd1});
        end
    endtask

    task automatic test_len_overflow();
        int c0;
        do_reset();
        c0 = wr_count;
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        checks++;
        if ({error, cpu_hold, loading, done} !== 4'b1100) begin
            failures++;
            $display("FAIL overflow_error: got %b, required 1100", {error, cpu_hold, loading, done});
        end
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        checks++;
        if ({error, done, words_loaded} !== {2'b10, 5'd0} || wr_count != c0) begin
            failures++;
            $display("FAIL overflow_sticky: got %b writes=%0d, required %b writes=0",
                     {error, done, words_loaded}, wr_count - c0, {2'b10, 5'd0});
        end
    endtask

    task automatic test_framing();
        do_reset();
        send_byte(8'h00, 1'b1);
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        checks++;
        if ({loading, error} !== 2'b10) begin
            failures++;
            $display("FAIL glitch_ignored: got loading,error=%b, required 10", {loading, error});
        end
        send_byte(8'h02, 1'b0);
        checks++;
        if ({error, cpu_hold, loading} !== 3'b110) begin
            failures++;
            $display("FAIL framing_error: got %b, required 110", {error, cpu_hold, loading});
        end
    endtask

    task automatic test_timeout();
        do_reset();
        send_byte(8'h00, 1'b1);
        send_byte(8'h03, 1'b1);
        send_word(4'd0, 16'h0001);
        repeat (900) @(negedge clk);
        checks++;
        if ({error, loading, words_loaded} !== {2'b01, 5'd1} || sb.size() != 0) begin
            failures++;
            $display("FAIL timeout_early: got %b pending=%0d, required %b pending=0",
                     {error, loading, words_loaded}, sb.size(), {2'b01, 5'd1});
        end
        repeat (101) @(negedge clk);
        checks++;
        if ({error, cpu_hold, loading, done} !== 4'b1100) begin
            failures++;
            $display("FAIL timeout_error: got %b, required 1100", {error, cpu_hold, loading, done});
        end
    endtask

    task automatic test_zero_len();
        int c0;
        do_reset();
        c0 = wr_count;
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
`endif
        wait_done();
        checks++;
        if ({done, cpu_hold, error, words_loaded} !== {3'b100, 5'd0} || wr_count != c0) begin
            failures++;
            $display("FAIL zero_len: got %b writes=%0d, required %b writes=0",
                     {done, cpu_hold, error, words_loaded}, wr_count - c0, {3'b100, 5'd0});
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int c0;
        do_reset();
        c0 = wr_count;
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_word(4'd0, 16'h1234);
        send_word(4'd1, 16'hABCD);
        send_byte(8'hBE, 1'b1);
        send_byte(8'h02, 1'b1);
        checks++;
        if ({error, done, cpu_hold} !== 3'b101 || wr_count - c0 != 2 || sb.size() != 0) begin
            failures++;
            $display("FAIL checksum_mismatch: got %b writes=%0d, required 101 writes=2",
                     {error, done, cpu_hold}, wr_count - c0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_load();
        test_reload();
        test_len_overflow();
        test_framing();
        test_timeout();
        test_zero_len();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
